// File: rtl/fifo_rd_sched_if.sv
// Read-port bundle between the FIFO/consumers and the burst read scheduler.
// The scheduler uses the master modport; FIFO and consumer side uses slave.
interface fifo_rd_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned LW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] blen;
    logic [NREQ-1:0]    cready;
    logic               rempty;
    logic [DW-1:0]      rdata;
    logic               rinc;
    logic [NREQ-1:0]    gnt;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               out_last;
    logic               out_abort;
    logic               busy;

    modport master (
        input  req, blen, cready, rempty, rdata,
        output rinc, gnt, out_valid, out_data, out_last, out_abort, busy
    );

    modport slave (
        output req, blen, cready, rempty, rdata,
        input  rinc, gnt, out_valid, out_data, out_last, out_abort, busy
    );
endinterface

// File: rtl/fifo_rd_sched.sv
// Round-robin burst scheduler sharing one FIFO read port among NREQ consumers,
// with an empty-stall timeout that aborts a burst the FIFO cannot feed.
module fifo_rd_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned LW   = 4,
    parameter int unsigned TMO  = 16
) (
    input  logic            rclk,
    input  logic            rrst_n,
    fifo_rd_sched_if.master bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SW = $clog2(TMO + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic [IW-1:0]   last_q, last_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            out_abort_q, out_abort_d;
    logic            busy_q, busy_d;

    logic            any_req_c;
    logic            arb_found_c;
    logic [IW-1:0]   arb_idx_c;
    logic [IW-1:0]   win_c;
    logic            owner_rdy_c;
    logic            rinc_c;
    logic            stalled_c;
    logic            timeout_c;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        any_req_c   = |bus.req;
        arb_found_c = 1'b0;
        arb_idx_c   = last_q;
        win_c       = last_q;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            arb_idx_c = IW'((32'(last_q) + i) % NREQ);
            if (!arb_found_c && bus.req[arb_idx_c]) begin
                arb_found_c = 1'b1;
                win_c       = arb_idx_c;
            end
        end
    end

    // Owner readiness is taken through the one-hot grant, so no owner index flop is needed.
    always_comb begin
        owner_rdy_c = |(bus.cready & gnt_q);
        rinc_c      = (state_q == BURST) & ~bus.rempty & owner_rdy_c;
        stalled_c   = (state_q == BURST) & bus.rempty & owner_rdy_c;
        timeout_c   = stalled_c & (stall_q == SW'(TMO - 1));
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            cnt_q       <= '0;
            stall_q     <= '0;
            last_q      <= IW'(NREQ - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_abort_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            stall_q     <= stall_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_abort_q <= out_abort_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req_c) state_d = BURST;
            BURST:   if ((rinc_c && (cnt_q == '0)) || timeout_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        stall_d     = stall_q;
        last_d      = last_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_last_d  = 1'b0;
        out_abort_d = 1'b0;
        busy_d      = (state_d == BURST);
        unique case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    gnt_d   = NREQ'(1) << win_c;
                    cnt_d   = bus.blen[32'(win_c) * LW +: LW];
                    stall_d = '0;
                    last_d  = win_c;
                end
            end
            BURST: begin
                if (rinc_c) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.rdata;
                    out_last_d  = (cnt_q == '0);
                    stall_d     = '0;
                    if (cnt_q != '0) cnt_d = cnt_q - LW'(1);
                    else             gnt_d = '0;
                end else if (timeout_c) begin
                    out_abort_d = 1'b1;
                    gnt_d       = '0;
                    stall_d     = '0;
                end else if (stalled_c) begin
                    stall_d = stall_q + SW'(1);
                end
            end
            default: gnt_d = '0;
        endcase
    end

    assign bus.rinc      = rinc_c;
    assign bus.gnt       = gnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_abort = out_abort_q;
    assign bus.busy      = busy_q;
endmodule
